axi_burst_ram_slave: RTL

//  Parametrised AXI4 burst-capable RAM slave on the tvip_axi signal set. FIXED/INCR/WRAP bursts, byte strobes, SLVERR on bad access.

---
 rtl/axi_burst_ram_slave.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_ram_slave.sv
// AXI4 burst RAM slave: FIXED/INCR/WRAP bursts, byte strobes, SLVERR on out-of-range
// beats, bad WLAST framing or illegal burst encodings. Independent read and write FSMs.
module axi_burst_ram_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESETN,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [ID_WIDTH-1:0]     AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]   AXI_AWADDR,
  input  logic [7:0]              AXI_AWLEN,
  input  logic [1:0]              AXI_AWBURST,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  input  logic [DATA_WIDTH-1:0]   AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WLAST,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  output logic [ID_WIDTH-1:0]     AXI_BID,
  output logic [1:0]              AXI_BRESP,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  input  logic [ID_WIDTH-1:0]     AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]   AXI_ARADDR,
  input  logic [7:0]              AXI_ARLEN,
  input  logic [1:0]              AXI_ARBURST,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY,
  output logic [ID_WIDTH-1:0]     AXI_RID,
  output logic [DATA_WIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RLAST
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int BB = $clog2(NB);
  localparam int WF = ADDR_WIDTH - BB;
  localparam int DW = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic f_illegal(input logic [7:0] len, input logic [1:0] burst);
    case (burst)
      2'b00, 2'b01: f_illegal = 1'b0;
      2'b10:        f_illegal = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      default:      f_illegal = 1'b1;
    endcase
  endfunction

  // Illegal bursts are stored as INCR so the address walk needs no error awareness.
  function automatic logic [1:0] f_eff_burst(input logic [7:0] len, input logic [1:0] burst);
    f_eff_burst = f_illegal(len, burst) ? 2'b01 : burst;
  endfunction

  function automatic logic [WF-1:0] f_next(input logic [WF-1:0] idx, input logic [7:0] len,
                                           input logic [1:0] burst);
    logic [WF-1:0] mask;
    mask = WF'(len);
    case (burst)
      2'b00:   f_next = idx;
      2'b10:   f_next = (idx & ~mask) | ((idx + WF'(1)) & mask);
      default: f_next = idx + WF'(1);
    endcase
  endfunction

  function automatic logic f_in_range(input logic [WF-1:0] idx);
    f_in_range = ({1'b0, idx} < (WF+1)'(DEPTH));
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  w_state_t          r_wstate;
  logic              r_awready, r_wready, r_bvalid, r_werr;
  logic [ID_WIDTH-1:0] r_bid;
  logic [1:0]        r_bresp, r_wburst;
  logic [WF-1:0]     r_widx;
  logic [7:0]        r_wlen, r_wcnt;

  r_state_t          r_rstate;
  logic              r_arready, r_rvalid, r_rlast, r_rill;
  logic [ID_WIDTH-1:0] r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]        r_rresp, r_rburst;
  logic [WF-1:0]     r_ridx;
  logic [7:0]        r_rlen, r_rcnt;

  logic          w_wbeat, w_wr_en, w_wlast_beat, w_werr_all;
  logic [WF-1:0] w_rd_idx;
  logic          w_rd_ill;
  logic          w_unused_addr;

  assign w_wbeat      = AXI_ARESETN && (r_wstate == W_DATA) && r_wready && AXI_WVALID;
  assign w_wr_en      = w_wbeat && f_in_range(r_widx);
  assign w_wlast_beat = (r_wcnt == r_wlen);
  assign w_werr_all   = r_werr || !f_in_range(r_widx) || (AXI_WLAST != w_wlast_beat);
  assign w_rd_idx     = (r_rstate == R_IDLE) ? AXI_ARADDR[ADDR_WIDTH-1:BB]
                                             : f_next(r_ridx, r_rlen, r_rburst);
  assign w_rd_ill     = (r_rstate == R_IDLE) ? f_illegal(AXI_ARLEN, AXI_ARBURST) : r_rill;
  assign w_unused_addr = ^{AXI_AWADDR[BB-1:0], AXI_ARADDR[BB-1:0]};

  // Memory is never reset so contents survive AXI_ARESETN.
  always_ff @(posedge AXI_ACLK) begin
    for (int b = 0; b < NB; b++) begin
      if (w_wr_en && AXI_WSTRB[b]) r_mem[r_widx[DW-1:0]][b*8 +: 8] <= AXI_WDATA[b*8 +: 8];
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      r_wstate <= W_IDLE;
      r_awready <= 1'b0;
      r_wready <= 1'b0;
      r_bvalid <= 1'b0;
      r_bid <= '0;
      r_bresp <= 2'b00;
      r_widx <= '0;
      r_wlen <= 8'd0;
      r_wburst <= 2'b00;
      r_wcnt <= 8'd0;
      r_werr <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (AXI_AWVALID && r_awready) begin
            r_bid <= AXI_AWID;
            r_widx <= AXI_AWADDR[ADDR_WIDTH-1:BB];
            r_wlen <= AXI_AWLEN;
            r_wburst <= f_eff_burst(AXI_AWLEN, AXI_AWBURST);
            r_werr <= f_illegal(AXI_AWLEN, AXI_AWBURST);
            r_wcnt <= 8'd0;
            r_awready <= 1'b0;
            r_wready <= 1'b1;
            r_wstate <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_wbeat) begin
            r_widx <= f_next(r_widx, r_wlen, r_wburst);
            r_wcnt <= r_wcnt + 8'd1;
            r_werr <= w_werr_all;
            if (w_wlast_beat) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp <= w_werr_all ? 2'b10 : 2'b00;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (AXI_BREADY) begin
            r_bvalid <= 1'b0;
            r_bresp <= 2'b00;
            r_awready <= 1'b1;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read beats are fetched on the capturing edge, so a same-edge write is not visible.
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      r_rstate <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid <= 1'b0;
      r_rlast <= 1'b0;
      r_rid <= '0;
      r_rdata <= '0;
      r_rresp <= 2'b00;
      r_ridx <= '0;
      r_rlen <= 8'd0;
      r_rburst <= 2'b00;
      r_rcnt <= 8'd0;
      r_rill <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (AXI_ARVALID && r_arready) begin
            r_rid <= AXI_ARID;
            r_ridx <= w_rd_idx;
            r_rlen <= AXI_ARLEN;
            r_rburst <= f_eff_burst(AXI_ARLEN, AXI_ARBURST);
            r_rill <= w_rd_ill;
            r_rcnt <= 8'd0;
            r_arready <= 1'b0;
            r_rvalid <= 1'b1;
            r_rdata <= f_in_range(w_rd_idx) ? r_mem[w_rd_idx[DW-1:0]] : '0;
            r_rresp <= (w_rd_ill || !f_in_range(w_rd_idx)) ? 2'b10 : 2'b00;
            r_rlast <= (AXI_ARLEN == 8'd0);
            r_rstate <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (AXI_RREADY) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast <= 1'b0;
              r_rresp <= 2'b00;
              r_arready <= 1'b1;
              r_rstate <= R_IDLE;
            end else begin
              r_ridx <= w_rd_idx;
              r_rcnt <= r_rcnt + 8'd1;
              r_rdata <= f_in_range(w_rd_idx) ? r_mem[w_rd_idx[DW-1:0]] : '0;
              r_rresp <= (w_rd_ill || !f_in_range(w_rd_idx)) ? 2'b10 : 2'b00;
              r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign AXI_AWREADY = r_awready;
  assign AXI_WREADY  = r_wready;
  assign AXI_BVALID  = r_bvalid;
  assign AXI_BID     = r_bid;
  assign AXI_BRESP   = r_bresp;
  assign AXI_ARREADY = r_arready;
  assign AXI_RVALID  = r_rvalid;
  assign AXI_RID     = r_rid;
  assign AXI_RDATA   = r_rdata;
  assign AXI_RRESP   = r_rresp;
  assign AXI_RLAST   = r_rlast;
endmodule
